// File: rtl/uart_block_assembler.sv
// Packs a UART byte stream (MSB-first) into 64-bit blocks, discarding partial frames on inter-byte timeout.
// Optional BLOCK_CHECKSUM_EN: 9-byte frames whose last byte is the XOR of the 8 data bytes.
module uart_block_assembler #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        block_valid,
  output logic [63:0] block_data,
  output logic        frame_err,
  output logic [3:0]  byte_cnt,
  output logic [1:0]  state_dbg
);

  // Handshake: byte_valid is a one-cycle strobe with no ready; block_valid and frame_err
  // are one-cycle pulses with no backpressure, block_data holds until the next block.
  localparam int TIMEOUT_CYCLES = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef BLOCK_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, CHECK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [63:0]   shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          bv_d, fe_d;
  logic [63:0]   bd_d;
`ifdef BLOCK_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      shift_q     <= 64'h0;
      tmo_q       <= '0;
      cnt_q       <= 4'd0;
      block_valid <= 1'b0;
      block_data  <= 64'h0;
      frame_err   <= 1'b0;
`ifdef BLOCK_CHECKSUM_EN
      csum_q      <= 8'h0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      block_valid <= bv_d;
      block_data  <= bd_d;
      frame_err   <= fe_d;
`ifdef BLOCK_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    bd_d    = block_data;
`ifdef BLOCK_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (byte_valid) begin
          shift_d = {shift_q[55:0], byte_data};
          cnt_d   = 4'd1;
          state_d = COLLECT;
`ifdef BLOCK_CHECKSUM_EN
          csum_d  = byte_data;
`endif
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          // A byte arriving on the expiry cycle wins over the timeout.
          shift_d = {shift_q[55:0], byte_data};
          tmo_d   = '0;
`ifdef BLOCK_CHECKSUM_EN
          csum_d  = csum_q ^ byte_data;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = CHECK;
`else
          if (cnt_q == 4'd7) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            bd_d    = {shift_q[55:0], byte_data};
            bv_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          tmo_d   = '0;
          fe_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`ifdef BLOCK_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          tmo_d   = '0;
          if (byte_data == csum_q) begin
            bd_d = shift_q;
            bv_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          tmo_d   = '0;
          fe_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        tmo_d   = '0;
      end
    endcase
  end

  assign byte_cnt  = cnt_q;
  assign state_dbg = state_q;

endmodule
